// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch responder: PC owner, instruction-bus handshake, flush redirect
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_kind,
  input  logic [63:0] cmd_offset,
  input  logic [63:0] cmd_target,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [63:0] iresp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_err,
  output logic        iwait
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] KIND_HOLD = 2'd0;
  localparam logic [1:0] KIND_SEQ  = 2'd1;
  localparam logic [1:0] KIND_REL  = 2'd2;
  localparam logic [1:0] KIND_ABS  = 2'd3;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        redir_pend_q, redir_pend_d;
  logic [63:0] redir_pc_q, redir_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        inst_err_q, inst_err_d;
  logic        inst_valid_q, inst_valid_d;

  logic [63:0] flush_tgt;
  logic        load_pc;
  logic [63:0] load_val;
  logic        accepted;
  logic        drop_eff;

  // Next-state logic: command decode in IDLE, handshake and flush bookkeeping while busy
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_err_d   = inst_err_q;
    load_pc      = 1'b0;
    load_val     = pc_q;

    flush_tgt = flush_pc & ~64'h1;
    // An address already accepted means the bus owes us exactly one data beat.
    accepted  = (state_q == WAIT) || ((state_q == REQ) && iresp_addr_ok);
    // A flush seen during REQ is only latched as pending; it turns into a drop once accepted.
    drop_eff  = (state_q == WAIT) ? drop_q : redir_pend_q;

    case (state_q)
      IDLE: begin
        if (flush) begin
          load_pc  = 1'b1;
          load_val = flush_tgt;
        end else if (cmd_valid) begin
          case (cmd_kind)
            KIND_SEQ: begin
              load_pc  = 1'b1;
              load_val = inst_pc_q + 64'd4;
            end
            KIND_REL: begin
              load_pc  = 1'b1;
              load_val = inst_pc_q + cmd_offset;
            end
            KIND_ABS: begin
              load_pc  = 1'b1;
              load_val = cmd_target & ~64'h1;
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (!accepted) begin
          // Request stays up with the old address; remember where to go afterwards.
          if (flush) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = flush_tgt;
          end
        end else if (iresp_data_ok) begin
          drop_d       = 1'b0;
          redir_pend_d = 1'b0;
          if (flush) begin
            load_pc  = 1'b1;
            load_val = flush_tgt;
          end else if (drop_eff) begin
            load_pc  = 1'b1;
            load_val = redir_pc_q;
          end else begin
            inst_d     = pc_q[2] ? iresp_data[63:32] : iresp_data[31:0];
            inst_pc_d  = pc_q;
            inst_err_d = 1'b0;
            state_d    = IDLE;
          end
        end else begin
          state_d = WAIT;
          if (flush) begin
            drop_d     = 1'b1;
            redir_pc_d = flush_tgt;
          end else if ((state_q == REQ) && redir_pend_q) begin
            drop_d = 1'b1;
          end
        end
      end
    endcase

    // Every new PC is checked for alignment; a misaligned one never reaches the bus.
    if (load_pc) begin
      pc_d         = load_val;
      drop_d       = 1'b0;
      redir_pend_d = 1'b0;
      if (load_val[1:0] != 2'b00) begin
        inst_d     = 32'd0;
        inst_pc_d  = load_val;
        inst_err_d = 1'b1;
        state_d    = IDLE;
      end else begin
        state_d = REQ;
      end
    end

    inst_valid_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 64'd0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 64'd0;
      inst_err_q   <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign ireq_valid = (state_q == REQ);
  assign ireq_addr  = pc_q;
  assign iwait      = (state_q != IDLE);
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = inst_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_kind = 2'd0;
  logic [63:0] cmd_offset = 64'd0;
  logic [63:0] cmd_target = 64'd0;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = 64'd0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [63:0] iresp_data = 64'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_err;
  logic        iwait;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_kind(cmd_kind), .cmd_offset(cmd_offset), .cmd_target(cmd_target),
    .flush(flush), .flush_pc(flush_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .iwait(iwait)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
    logic        err;
  } inst_t;

  logic [63:0] exp_addr_q[$];
  inst_t       exp_inst_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_valid = 1'b0;
  logic        prev_accept = 1'b0;

  // Monitor: pops expectations whenever the DUT hands out a bus address or a fresh instruction
  always @(negedge clk) begin
    logic [63:0] ea;
    inst_t       ei;
    if (reset) begin
      prev_valid  = 1'b0;
      prev_accept = 1'b0;
    end else begin
      if (ireq_valid && iresp_addr_ok) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL addr_unexpected: got %h, required no request", ireq_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (ireq_addr !== ea) begin
            errors++;
            $display("FAIL ireq_addr: got %h, required %h", ireq_addr, ea);
          end
        end
      end
      if (inst_valid && (!prev_valid || prev_accept)) begin
        checks++;
        if (exp_inst_q.size() == 0) begin
          errors++;
          $display("FAIL inst_unexpected: got inst %h pc %h err %b, required none", inst, inst_pc, inst_err);
        end else begin
          ei = exp_inst_q.pop_front();
          if (inst !== ei.ins || inst_pc !== ei.pc || inst_err !== ei.err) begin
            errors++;
            $display("FAIL inst_out: got inst %h pc %h err %b, required inst %h pc %h err %b",
                     inst, inst_pc, inst_err, ei.ins, ei.pc, ei.err);
          end
        end
      end
      prev_valid  = inst_valid;
      prev_accept = !iwait && (flush || (cmd_valid && cmd_kind != 2'd0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_addr(input logic [63:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_inst(input logic [31:0] i, input logic [63:0] p, input logic e);
    inst_t t;
    t.ins = i;
    t.pc  = p;
    t.err = e;
    exp_inst_q.push_back(t);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !ireq_valid; i++) step();
    checks++;
    if (!ireq_valid) begin
      errors++;
      $display("FAIL wait_req_timeout: got ireq_valid %b, required 1", ireq_valid);
    end
  endtask

  task automatic bus_txn(input logic [63:0] d, input int addr_lat, input bit same);
    wait_req();
    repeat (addr_lat) step();
    iresp_addr_ok = 1'b1;
    if (same) begin
      iresp_data_ok = 1'b1;
      iresp_data    = d;
    end
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    if (!same) begin
      iresp_data_ok = 1'b1;
      iresp_data    = d;
      step();
      iresp_data_ok = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [1:0] k, input logic [63:0] off, input logic [63:0] tgt);
    cmd_valid  = 1'b1;
    cmd_kind   = k;
    cmd_offset = off;
    cmd_target = tgt;
    step();
    cmd_valid  = 1'b0;
    cmd_kind   = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ireq_valid", ireq_valid, 1);
    chk("rst_ireq_addr", ireq_addr, RST_PC);
    chk("rst_iwait", iwait, 1);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_err", inst_err, 0);

    // First fetch: addr_ok at cycle 1, data_ok at cycle 3
    push_addr(64'h8000_0000);
    push_inst(32'h0000_0093, 64'h8000_0000, 1'b0);
    step();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    step();
    iresp_data_ok = 1'b1;
    iresp_data    = 64'h0000_0013_0000_0093;
    step();
    iresp_data_ok = 1'b0;
    chk("first_inst_valid", inst_valid, 1);
    chk("first_iwait", iwait, 0);

    // SEQ picks the upper word
    push_addr(64'h8000_0004);
    push_inst(32'h0000_0013, 64'h8000_0004, 1'b0);
    send_cmd(2'd1, 64'd0, 64'd0);
    chk("seq_ireq_addr", ireq_addr, 64'h8000_0004);
    bus_txn(64'h0000_0013_0000_0093, 0, 1'b0);

    // REL with negative offset
    push_addr(64'h8000_0000);
    push_inst(32'h0000_0093, 64'h8000_0000, 1'b0);
    send_cmd(2'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    bus_txn(64'h0000_0013_0000_0093, 1, 1'b0);

    // ABS clears bit 0
    push_addr(64'h8000_0100);
    push_inst(32'h1234_5678, 64'h8000_0100, 1'b0);
    send_cmd(2'd3, 64'd0, 64'h8000_0101);
    bus_txn(64'hAAAA_BBBB_1234_5678, 0, 1'b0);

    // addr_ok and data_ok in the same cycle
    push_addr(64'h8000_0104);
    push_inst(32'hDEAD_BEEF, 64'h8000_0104, 1'b0);
    send_cmd(2'd1, 64'd0, 64'd0);
    bus_txn(64'hDEAD_BEEF_0000_0000, 0, 1'b1);
    chk("same_cycle_iwait", iwait, 0);

    // Flush during REQ with addr_ok low for two cycles: old address kept, its data dropped
    push_addr(64'h8000_0108);
    send_cmd(2'd1, 64'd0, 64'd0);
    flush    = 1'b1;
    flush_pc = 64'h8000_1000;
    step();
    flush = 1'b0;
    chk("flush_req_hold_addr", ireq_addr, 64'h8000_0108);
    step();
    chk("flush_req_hold_valid", ireq_valid, 1);
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 64'h5555_5555_6666_6666;
    step();
    iresp_data_ok = 1'b0;
    chk("flush_drop_inst_valid", inst_valid, 0);
    chk("flush_redirect_addr", ireq_addr, 64'h8000_1000);
    push_addr(64'h8000_1000);
    push_inst(32'h0000_0517, 64'h8000_1000, 1'b0);
    bus_txn(64'h1111_1111_0000_0517, 0, 1'b0);

    // Flush in the same cycle as data_ok
    push_addr(64'h8000_1004);
    send_cmd(2'd1, 64'd0, 64'd0);
    wait_req();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 64'h7777_7777_8888_8888;
    flush         = 1'b1;
    flush_pc      = 64'h8000_2001;
    step();
    iresp_data_ok = 1'b0;
    flush         = 1'b0;
    chk("flush_data_ireq_valid", ireq_valid, 1);
    chk("flush_data_ireq_addr", ireq_addr, 64'h8000_2000);
    chk("flush_data_inst_valid", inst_valid, 0);
    push_addr(64'h8000_2000);
    push_inst(32'h3333_3333, 64'h8000_2000, 1'b0);
    bus_txn(64'h2222_2222_3333_3333, 0, 1'b0);

    // Misaligned ABS: no bus request, error instruction next cycle, then HOLD keeps it
    push_inst(32'h0, 64'h8000_0002, 1'b1);
    send_cmd(2'd3, 64'd0, 64'h8000_0002);
    chk("mis_ireq_valid", ireq_valid, 0);
    chk("mis_iwait", iwait, 0);
    cmd_valid = 1'b1;
    cmd_kind  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_inst_valid", inst_valid, 1);
      chk("hold_inst", inst, 0);
      chk("hold_inst_pc", inst_pc, 64'h8000_0002);
      chk("hold_inst_err", inst_err, 1);
      chk("hold_ireq_valid", ireq_valid, 0);
    end
    cmd_valid = 1'b0;

    // Reset in the middle of a request returns to reset values at once
    send_cmd(2'd3, 64'd0, 64'h8000_0200);
    chk("pre_reset_addr", ireq_addr, 64'h8000_0200);
    reset = 1'b1;
    #1;
    chk("midrst_ireq_addr", ireq_addr, RST_PC);
    chk("midrst_ireq_valid", ireq_valid, 1);
    chk("midrst_inst_valid", inst_valid, 0);
    chk("midrst_inst_err", inst_err, 0);
    step();
    reset = 1'b0;
    step();
    step();

    chk("addr_queue_empty", exp_addr_q.size(), 0);
    chk("inst_queue_empty", exp_inst_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch responder for the hazard unit's fetch commands.
- Accepts the hazard unit's per-cycle command (hold / +4 / PC-relative redirect / absolute redirect), owns the PC, runs the instruction-bus handshake, and returns a held instruction with its PC to the IF/ID register.
- Drives `iwait` back to the hazard unit while a fetch is outstanding.
- Also services asynchronous-priority flushes (trap/CSR redirect) without ever withdrawing a bus request.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  hazard command present (`dataH.ireq_valid`)
- cmd_kind  in  2  0 HOLD, 1 SEQ (pc+4), 2 REL (inst_pc+cmd_offset), 3 ABS (cmd_target)
- cmd_offset  in  64  signed offset for REL
- cmd_target  in  64  absolute target for ABS (JALR result)
- flush  in  1  unconditional redirect
- flush_pc  in  64  flush target
- ireq_valid  out  1  bus request valid
- ireq_addr  out  64  bus request address
- iresp_addr_ok  in  1  request accepted
- iresp_data_ok  in  1  response data valid
- iresp_data  in  64  response doubleword
- inst_valid  out  1  inst/inst_pc/inst_err valid and held
- inst  out  32  fetched instruction
- inst_pc  out  64  PC of `inst`
- inst_err  out  1  misaligned fetch, `inst`=0
- iwait  out  1  fetch unit busy; hazard command ignored

Behaviour:
- States: IDLE, REQ, WAIT. Registers: `pc`, `drop`, `redir_pend`, `redir_pc`, `inst`, `inst_pc`, `inst_err`, `inst_valid`.
- Reset values:
  - state=REQ, pc=RESET_PC, drop=0, redir_pend=0.
  - inst_valid=0, inst=0, inst_pc=0, inst_err=0.
  - ireq_valid=1 combinationally out of reset (state=REQ), ireq_addr=RESET_PC.
- Outputs by state:
  - iwait=1 in REQ and WAIT, 0 in IDLE.
  - ireq_valid=1 only in REQ; ireq_addr=pc.
  - inst_valid=1 only in IDLE.
- REQ:
  - ireq_addr held stable until `iresp_addr_ok`.
  - On addr_ok: go to WAIT.
  - If addr_ok and data_ok arrive in the same cycle, treat it as the WAIT completion that cycle.
- WAIT, on data_ok:
  - drop=0: inst=iresp_data[pc[2]*32 +: 32], inst_pc=pc, inst_err=0, go to IDLE.
  - drop=1: discard the data, clear drop, pc=redir_pc, clear redir_pend, go to REQ.
- IDLE (cmd accepted only here, only when cmd_valid=1):
  - HOLD or cmd_valid=0: stay; outputs unchanged.
  - SEQ: pc=inst_pc+4. REL: pc=inst_pc+cmd_offset. ABS: pc=cmd_target & ~64'h1. Any of these then goes to REQ.
  - 64-bit wrap-around arithmetic.
- Misalignment check on every new pc (cmd or flush):
  - If new pc[1:0]!=0, no bus request is issued.
  - Go to IDLE next cycle with inst=0, inst_pc=new pc, inst_err=1.
- Flush (priority over cmd, any state):
  - Target is flush_pc & ~1.
  - IDLE: behaves as ABS.
  - REQ without addr_ok: redir_pend=1, redir_pc=target; request stays asserted with the old address. When addr_ok arrives: go to WAIT with drop=1.
  - REQ with addr_ok same cycle: WAIT, drop=1, redir_pc=target.
  - WAIT without data_ok: drop=1, redir_pc=target.
  - WAIT with data_ok same cycle: discard the data, pc=target, go to REQ.
  - A later flush overwrites redir_pc (last flush wins).
- Commands while iwait=1 are ignored; the hazard unit re-presents them. At most one bus transaction is outstanding.
- Reset mid-transaction: all state returns to reset values immediately. A late data_ok from the bus after reset is not expected (bus is reset together).

Test Plan:
- Reset release, bus answers addr_ok at cycle 1 and data_ok at cycle 3 with data 64'h0000_0013_0000_0093 -> ireq_addr=0x8000_0000; inst_valid=1 from cycle 4 with inst=0x0000_0093, inst_pc=0x8000_0000, iwait=0.
- Then cmd SEQ -> ireq_addr=0x8000_0004 next cycle; returned inst=0x0000_0013 (upper word), inst_pc=0x8000_0004.
- From inst_pc=0x8000_0004: cmd REL with offset=-4 -> fetch 0x8000_0000. cmd ABS target=0x8000_0101 -> fetch 0x8000_0100.
- Flush to 0x8000_1000 while in REQ with addr_ok held low 2 cycles -> old address is held until accepted, its data is dropped (inst_valid stays 0), next request is 0x8000_1000.
- Flush in the same cycle as data_ok -> data discarded; next cycle ireq_addr=flush_pc.
- cmd ABS target=0x8000_0002 -> no ireq_valid; next cycle inst_valid=1, inst_err=1, inst=0, inst_pc=0x8000_0002. cmd HOLD for 5 cycles -> all outputs stable.
